// File: rtl/serial_frame_tx.sv
// serial_frame_tx: parallel-to-serial frame transmitter.
// Each accepted word is sent as start(0), data LSB-first, optional even
// parity, stop(1). Every serial level is held BIT_CYCLES clocks. All state and
// the line itself launch on the rising edge, so negedge samplers downstream
// get half a cycle of margin.
module serial_frame_tx #(
    parameter int WIDTH      = 8,
    parameter int BIT_CYCLES = 1,
    parameter int PARITY_EN  = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(BIT_CYCLES + 1);
    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CYC = CW'(BIT_CYCLES - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t           state;
    logic [CW-1:0]    cyc_cnt;
    logic [BW-1:0]    bit_cnt;
    logic [WIDTH-1:0] shift_reg;
    logic             parity_bit;
    logic             bit_end;

    // The current serial level has been held for its full bit period.
    assign bit_end  = (cyc_cnt == LAST_CYC);

    // Ready in IDLE, and in the final cycle of the stop bit so a waiting word
    // can start immediately with no idle gap between frames.
    assign in_ready = (state == IDLE) || ((state == STOP) && bit_end);

    // Frame sequencer: owns the state, bit timing, shift register and the
    // registered line/busy/done outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cyc_cnt    <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            parity_bit <= 1'b0;
            out        <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    out  <= 1'b1;
                    busy <= 1'b0;
                    if (in_valid) begin
                        shift_reg  <= in_data;
                        parity_bit <= ^in_data;
                        cyc_cnt    <= '0;
                        bit_cnt    <= '0;
                        out        <= 1'b0;
                        busy       <= 1'b1;
                        state      <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        cyc_cnt   <= '0;
                        bit_cnt   <= '0;
                        out       <= shift_reg[0];
                        shift_reg <= shift_reg >> 1;
                        state     <= DATA;
                    end else begin
                        cyc_cnt <= cyc_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        cyc_cnt <= '0;
                        if (bit_cnt == LAST_BIT) begin
                            if (PARITY_EN != 0) begin
                                out   <= parity_bit;
                                state <= PARITY;
                            end else begin
                                out   <= 1'b1;
                                state <= STOP;
                            end
                        end else begin
                            bit_cnt   <= bit_cnt + 1'b1;
                            out       <= shift_reg[0];
                            shift_reg <= shift_reg >> 1;
                        end
                    end else begin
                        cyc_cnt <= cyc_cnt + 1'b1;
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        cyc_cnt <= '0;
                        out     <= 1'b1;
                        state   <= STOP;
                    end else begin
                        cyc_cnt <= cyc_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        done    <= 1'b1;
                        cyc_cnt <= '0;
                        if (in_valid) begin
                            shift_reg  <= in_data;
                            parity_bit <= ^in_data;
                            bit_cnt    <= '0;
                            out        <= 1'b0;
                            busy       <= 1'b1;
                            state      <= START;
                        end else begin
                            out   <= 1'b1;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end else begin
                        cyc_cnt <= cyc_cnt + 1'b1;
                    end
                end
                default: begin
                    cyc_cnt <= '0;
                    out     <= 1'b1;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_frame_tx.sv
// tb_serial_frame_tx: self-checking bench for serial_frame_tx.
// Four instances with different parameter sets share clock and reset. A
// behavioural model builds the expected per-cycle line/busy/ready/done trace
// for a stream of words directly from the frame format, and the trace is
// compared against each instance on the falling edge.
module tb_serial_frame_tx;

    localparam int MAXC = 1024;

    logic       clk;
    logic       rst_n;
    logic [3:0] in_valid_v;
    logic [7:0] in_data0;
    logic [7:0] in_data1;
    logic [7:0] in_data2;
    logic [2:0] in_data3;
    logic [3:0] ready_v;
    logic [3:0] out_v;
    logic [3:0] busy_v;
    logic [3:0] done_v;

    int checks;
    int errors;

    logic [7:0] word_q[$];

    serial_frame_tx #(.WIDTH(8), .BIT_CYCLES(1), .PARITY_EN(0)) dut0 (
        .clock(clk), .reset(rst_n), .in_data(in_data0), .in_valid(in_valid_v[0]),
        .in_ready(ready_v[0]), .out(out_v[0]), .busy(busy_v[0]), .done(done_v[0]));

    serial_frame_tx #(.WIDTH(8), .BIT_CYCLES(1), .PARITY_EN(1)) dut1 (
        .clock(clk), .reset(rst_n), .in_data(in_data1), .in_valid(in_valid_v[1]),
        .in_ready(ready_v[1]), .out(out_v[1]), .busy(busy_v[1]), .done(done_v[1]));

    serial_frame_tx #(.WIDTH(8), .BIT_CYCLES(4), .PARITY_EN(0)) dut2 (
        .clock(clk), .reset(rst_n), .in_data(in_data2), .in_valid(in_valid_v[2]),
        .in_ready(ready_v[2]), .out(out_v[2]), .busy(busy_v[2]), .done(done_v[2]));

    serial_frame_tx #(.WIDTH(3), .BIT_CYCLES(2), .PARITY_EN(1)) dut3 (
        .clock(clk), .reset(rst_n), .in_data(in_data3), .in_valid(in_valid_v[3]),
        .in_ready(ready_v[3]), .out(out_v[3]), .busy(busy_v[3]), .done(done_v[3]));

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int cfg_w(input int k);
        return (k == 3) ? 3 : 8;
    endfunction

    function automatic int cfg_bc(input int k);
        return (k == 2) ? 4 : ((k == 3) ? 2 : 1);
    endfunction

    function automatic int cfg_p(input int k);
        return (k == 1 || k == 3) ? 1 : 0;
    endfunction

    // Serial bit number idx of the frame carrying word.
    function automatic bit frame_bit(input logic [7:0] word, input int w, input int p, input int idx);
        logic [7:0] mask;
        mask = 8'((1 << w) - 1);
        if (idx == 0) return 1'b0;
        if (idx <= w) return word[idx-1];
        if (p != 0 && idx == w + 1) return ($countones(word & mask) % 2) == 1;
        return 1'b1;
    endfunction

    task automatic drive(input int k, input logic v, input logic [7:0] d);
        in_valid_v[k] = v;
        case (k)
            0: in_data0 = d;
            1: in_data1 = d;
            2: in_data2 = d;
            default: in_data3 = d[2:0];
        endcase
    endtask

    // Sends every word in word_q on instance k with 'gap' cycles between
    // frames (0 = back-to-back); junk pulses in_valid=1/data=FF while busy.
    task automatic run_stream(input int k, input int gap, input bit junk, input string name);
        int w, bc, p, flen, t, end_t, ncyc, n;
        bit e_out[MAXC];
        bit e_busy[MAXC];
        bit e_rdy[MAXC];
        bit e_done[MAXC];
        bit d_val[MAXC];
        logic [7:0] d_dat[MAXC];
        w = cfg_w(k);
        bc = cfg_bc(k);
        p = cfg_p(k);
        flen = (2 + w + p) * bc;
        n = word_q.size();
        ncyc = 0;
        for (int c = 0; c < MAXC; c++) begin
            e_out[c] = 1'b1;
            e_busy[c] = 1'b0;
            e_rdy[c] = 1'b1;
            e_done[c] = 1'b0;
            d_val[c] = 1'b0;
            d_dat[c] = 8'($urandom);
        end
        t = 0;
        d_val[0] = 1'b1;
        d_dat[0] = word_q[0];
        for (int j = 0; j < n; j++) begin
            for (int c = 1; c <= flen; c++) begin
                e_out[t+c] = frame_bit(word_q[j], w, p, (c - 1) / bc);
                e_busy[t+c] = 1'b1;
                e_rdy[t+c] = (c == flen);
                e_done[t+c] = (c == 1 && j > 0 && gap == 0);
            end
            end_t = t + flen;
            if (j < n - 1) begin
                if (gap == 0) begin
                    t = end_t;
                end else begin
                    e_done[end_t+1] = 1'b1;
                    t = end_t + gap;
                end
                d_val[t] = 1'b1;
                d_dat[t] = word_q[j+1];
            end else begin
                e_done[end_t+1] = 1'b1;
                ncyc = end_t + 3;
            end
        end
        if (junk) begin
            for (int c = 0; c < ncyc; c++) begin
                if (!d_val[c] && !e_rdy[c] && $urandom_range(0, 2) == 0) begin
                    d_val[c] = 1'b1;
                    d_dat[c] = 8'hFF;
                end
            end
        end
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            checks++;
            if (out_v[k] !== e_out[c]) begin
                errors++;
                $display("[TB] FAIL %s out k=%0d cyc=%0d got %b exp %b", name, k, c, out_v[k], e_out[c]);
            end
            checks++;
            if (busy_v[k] !== e_busy[c]) begin
                errors++;
                $display("[TB] FAIL %s busy k=%0d cyc=%0d got %b exp %b", name, k, c, busy_v[k], e_busy[c]);
            end
            checks++;
            if (ready_v[k] !== e_rdy[c]) begin
                errors++;
                $display("[TB] FAIL %s in_ready k=%0d cyc=%0d got %b exp %b", name, k, c, ready_v[k], e_rdy[c]);
            end
            checks++;
            if (done_v[k] !== e_done[c]) begin
                errors++;
                $display("[TB] FAIL %s done k=%0d cyc=%0d got %b exp %b", name, k, c, done_v[k], e_done[c]);
            end
            drive(k, d_val[c], d_dat[c]);
        end
    endtask

    task automatic check_idle(input int k, input string name);
        checks++;
        if (out_v[k] !== 1'b1 || busy_v[k] !== 1'b0 || ready_v[k] !== 1'b1 || done_v[k] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s k=%0d out/busy/rdy/done got %b%b%b%b exp 1010", name, k,
                     out_v[k], busy_v[k], ready_v[k], done_v[k]);
        end
    endtask

    // Reset state on every instance, then a handshake on the first edge after release.
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 4; k++) check_idle(k, "reset_state");
        @(posedge clk);
        #1 rst_n = 1'b1;
        word_q = {8'h3C};
        run_stream(0, 1, 1'b0, "first_after_reset");
    endtask

    // Reset asserted in the middle of a data bit clears the line at once.
    task automatic test_reset_mid_frame();
        @(negedge clk);
        drive(0, 1'b1, 8'h00);
        @(negedge clk);
        drive(0, 1'b0, 8'h00);
        repeat (3) @(negedge clk);
        checks++;
        if (out_v[0] !== 1'b0 || busy_v[0] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mid_frame_pre out/busy got %b%b exp 01", out_v[0], busy_v[0]);
        end
        #2 rst_n = 1'b0;
        #1 check_idle(0, "reset_mid_frame");
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check_idle(0, "no_done_after_reset");
        end
    endtask

    task automatic test_basic_a5();
        word_q = {8'hA5};
        run_stream(0, 1, 1'b0, "basic_a5");
    endtask

    task automatic test_parity();
        word_q = {8'h07, 8'h03};
        run_stream(1, 2, 1'b0, "parity");
    endtask

    task automatic test_back_to_back();
        word_q = {8'h01, 8'h80};
        run_stream(0, 0, 1'b0, "back_to_back");
        word_q = {8'h5, 8'h2, 8'h7};
        run_stream(3, 0, 1'b0, "back_to_back_w3");
    endtask

    task automatic test_bit_cycles();
        word_q = {8'h0F};
        run_stream(2, 1, 1'b0, "bit_cycles4");
    endtask

    task automatic test_busy_ignore();
        word_q = {8'h5A, 8'h3C};
        run_stream(0, 1, 1'b1, "busy_ignore");
        word_q = {8'hC3};
        run_stream(2, 1, 1'b1, "busy_ignore_bc4");
    endtask

    task automatic test_random();
        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < 4; k++) begin
                int n;
                n = $urandom_range(1, 4);
                word_q = {};
                for (int i = 0; i < n; i++) word_q.push_back(8'($urandom));
                run_stream(k, $urandom_range(0, 2), 1'b1, "random");
            end
        end
    endtask

    // Test sequence and summary.
    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        in_valid_v = 4'b0;
        in_data0 = 8'h00;
        in_data1 = 8'h00;
        in_data2 = 8'h00;
        in_data3 = 3'b000;
        test_reset();
        test_reset_mid_frame();
        test_basic_a5();
        test_parity();
        test_back_to_back();
        test_bit_cycles();
        test_busy_ignore();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
